// File: rtl/filter_16b_4tap_m2_deconv_if.sv
// Stream bundle for the FIR deconvolver: filtered words in, recovered samples out,
// plus a history seed port.
interface filter_16b_4tap_m2_deconv_if #(
  parameter int DW = 16,
  parameter int OW = 20
);
  // Handshake: a word moves on a rising clock edge where valid && ready are both 1.
  // The sender holds valid and data stable until that edge; ready may depend on valid.
  logic              in_valid;
  logic              in_ready;
  logic [OW-1:0]     in_data;
  logic              seed_valid;
  logic [3*DW-1:0]   seed_data;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_data;
  logic [4*DW-1:0]   out_window;

  modport master (
    output in_valid, in_data, seed_valid, seed_data, out_ready,
    input  in_ready, out_valid, out_data, out_window
  );

  modport slave (
    input  in_valid, in_data, seed_valid, seed_data, out_ready,
    output in_ready, out_valid, out_data, out_window
  );
endinterface

// File: rtl/filter_16b_4tap_m2_deconv.sv
// Streaming inverse of the 4-tap FIR y = x + C1*x[n-1] + C2*x[n-2] + C3*x[n-3] (mod 2^OW).
// Recovers x[n] from y[n] and the three previously recovered samples.
module filter_16b_4tap_m2_deconv #(
  parameter int DW   = 16,
  parameter int OW   = 20,
  parameter int C1   = 2,
  parameter int C2   = 3,
  parameter int C3   = 4,
  parameter int CNTW = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  filter_16b_4tap_m2_deconv_if.slave        bus,
  output logic [CNTW-1:0]                   sample_cnt
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  localparam logic [OW-1:0] K1 = OW'(C1);
  localparam logic [OW-1:0] K2 = OW'(C2);
  localparam logic [OW-1:0] K3 = OW'(C3);

  logic [0:0]      state;
  logic [DW-1:0]   h1, h2, h3;
  logic [DW-1:0]   out_data_q;
  logic [4*DW-1:0] out_window_q;
  logic [OW-1:0]   x_full;
  logic [DW-1:0]   x;
  logic            accept;

  // Low DW bits of the modular difference are exact because 2^DW divides 2^OW.
  assign x_full = bus.in_data - K1 * OW'(h1) - K2 * OW'(h2) - K3 * OW'(h3);
  assign x      = x_full[DW-1:0];

  assign bus.in_ready   = !rst && !bus.seed_valid && ((state == ST_EMPTY) || bus.out_ready);
  assign accept         = bus.in_valid && bus.in_ready;
  assign bus.out_valid  = (state == ST_FULL);
  assign bus.out_data   = out_data_q;
  assign bus.out_window = out_window_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_EMPTY;
      h1           <= '0;
      h2           <= '0;
      h3           <= '0;
      out_data_q   <= '0;
      out_window_q <= '0;
      sample_cnt   <= '0;
    end else begin
      // Seed and accept never coincide: in_ready is low while seeding.
      if (bus.seed_valid) begin
        h1         <= bus.seed_data[DW-1:0];
        h2         <= bus.seed_data[2*DW-1:DW];
        h3         <= bus.seed_data[3*DW-1:2*DW];
        sample_cnt <= '0;
      end else if (accept) begin
        h1         <= x;
        h2         <= h1;
        h3         <= h2;
        sample_cnt <= sample_cnt + CNTW'(1);
      end

      if (accept) begin
        out_data_q   <= x;
        out_window_q <= {h3, h2, h1, x};
        state        <= ST_FULL;
      end else if ((state == ST_FULL) && bus.out_ready) begin
        state        <= ST_EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_filter_16b_4tap_m2_deconv.sv
// Bench for the FIR deconvolver: vector table, directed corner sequences and a
// randomly stalled loopback through a bench-side FIR model.
module tb_filter_16b_4tap_m2_deconv;

  logic             clk;
  logic             rst;
  logic [15:0]      sample_cnt;
  int               errors;
  int               checks;

  filter_16b_4tap_m2_deconv_if #(.DW(16), .OW(20)) bus ();

  filter_16b_4tap_m2_deconv dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .sample_cnt (sample_cnt)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_first;
    logic [19:0] y;
    logic [15:0] x;
    logic [63:0] win;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[8];

  logic [15:0] exp_q[$];
  logic [19:0] y_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.seed_valid = 1'b0;
    bus.seed_data  = '0;
    bus.out_ready  = 1'b1;
    rst            = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Drives one y word and returns 1 time unit after the edge that took it.
  task automatic push(input logic [19:0] y);
    int w;
    bus.in_valid = 1'b1;
    bus.in_data  = y;
    w = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      w++;
      if (w >= 50) begin
        checks++;
        errors++;
        $display("FAIL push_timeout: in_ready low for %0d cycles, required 1", w);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;

    vecs[0] = '{1'b1, 20'h00001, 16'h0001, 64'h0000_0000_0000_0001, 16'd1};
    vecs[1] = '{1'b0, 20'h00004, 16'h0002, 64'h0000_0000_0001_0002, 16'd2};
    vecs[2] = '{1'b0, 20'h0000A, 16'h0003, 64'h0000_0001_0002_0003, 16'd3};
    vecs[3] = '{1'b0, 20'h00014, 16'h0004, 64'h0001_0002_0003_0004, 16'd4};
    vecs[4] = '{1'b1, 20'h0FFFF, 16'hFFFF, 64'h0000_0000_0000_FFFF, 16'd1};
    vecs[5] = '{1'b0, 20'h2FFFD, 16'hFFFF, 64'h0000_0000_FFFF_FFFF, 16'd2};
    vecs[6] = '{1'b0, 20'h5FFFA, 16'hFFFF, 64'h0000_FFFF_FFFF_FFFF, 16'd3};
    vecs[7] = '{1'b0, 20'h9FFF6, 16'hFFFF, 64'hFFFF_FFFF_FFFF_FFFF, 16'd4};

    // Reset: in_ready low under rst even with everything else ready
    bus.in_valid   = 1'b1;
    bus.in_data    = 20'h00001;
    bus.seed_valid = 1'b0;
    bus.seed_data  = '0;
    bus.out_ready  = 1'b1;
    rst            = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
    do_reset();
    @(negedge clk);
    check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_out_data", {48'd0, bus.out_data}, 64'd0);
    check("rst_out_window", bus.out_window, 64'd0);
    check("rst_sample_cnt", {48'd0, sample_cnt}, 64'd0);
    check("rst_in_ready_after", {63'd0, bus.in_ready}, 64'd1);

    // Table: back-to-back ramp and modular wrap
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].rst_first) do_reset();
      push(vecs[i].y);
      check($sformatf("vec%0d_valid", i), {63'd0, bus.out_valid}, 64'd1);
      check($sformatf("vec%0d_data", i), {48'd0, bus.out_data}, {48'd0, vecs[i].x});
      check($sformatf("vec%0d_window", i), bus.out_window, vecs[i].win);
      check($sformatf("vec%0d_cnt", i), {48'd0, sample_cnt}, {48'd0, vecs[i].cnt});
    end

    // Backpressure: held output stays put, next y waits for out_ready
    do_reset();
    push(20'h00001);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 20'h00004;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("bp%0d_in_ready", c), {63'd0, bus.in_ready}, 64'd0);
      check($sformatf("bp%0d_valid", c), {63'd0, bus.out_valid}, 64'd1);
      check($sformatf("bp%0d_data", c), {48'd0, bus.out_data}, 64'd1);
      check($sformatf("bp%0d_window", c), bus.out_window, 64'h0000_0000_0000_0001);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_in_ready_rise", {63'd0, bus.in_ready}, 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("bp_next_data", {48'd0, bus.out_data}, 64'd2);
    check("bp_next_window", bus.out_window, 64'h0000_0000_0001_0002);
    check("bp_next_cnt", {48'd0, sample_cnt}, 64'd2);
    @(posedge clk);
    #1;
    check("bp_drain_valid", {63'd0, bus.out_valid}, 64'd0);

    // Seed alongside in_valid: y waits one cycle, then uses the seeded history
    do_reset();
    bus.seed_valid = 1'b1;
    bus.seed_data  = 48'h0000_0000_0005;
    bus.in_valid   = 1'b1;
    bus.in_data    = 20'h0000B;
    @(negedge clk);
    check("seed_in_ready", {63'd0, bus.in_ready}, 64'd0);
    @(posedge clk);
    #1;
    bus.seed_valid = 1'b0;
    check("seed_no_accept", {63'd0, bus.out_valid}, 64'd0);
    @(negedge clk);
    check("seed_in_ready_next", {63'd0, bus.in_ready}, 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("seed_data_out", {48'd0, bus.out_data}, 64'd1);
    check("seed_window", bus.out_window, 64'h0000_0000_0005_0001);
    check("seed_cnt", {48'd0, sample_cnt}, 64'd1);

    // Reset mid-stream with a held output
    do_reset();
    push(20'h00001);
    push(20'h00004);
    bus.out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_valid", {63'd0, bus.out_valid}, 64'd0);
    check("mid_rst_cnt", {48'd0, sample_cnt}, 64'd0);
    bus.out_ready = 1'b1;
    push(20'h00007);
    check("mid_rst_data", {48'd0, bus.out_data}, 64'd7);
    check("mid_rst_window", bus.out_window, 64'h0000_0000_0000_0007);

    // Loopback through the FIR model with random stalls on both sides
    do_reset();
    exp_q.delete();
    y_q.delete();
    fork
      begin : producer
        logic [15:0] h1, h2, h3, xs;
        logic [19:0] ys;
        h1 = '0; h2 = '0; h3 = '0;
        for (int i = 0; i < 1000; i++) begin
          xs = 16'($urandom_range(0, 65535));
          ys = 20'(xs) + 20'd2 * 20'(h1) + 20'd3 * 20'(h2) + 20'd4 * 20'(h3);
          exp_q.push_back(xs);
          y_q.push_back(ys);
          h3 = h2; h2 = h1; h1 = xs;
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          push(ys);
        end
      end
      begin : consumer
        int got;
        int cyc;
        logic [15:0] ex;
        logic [19:0] ey;
        logic [63:0] w;
        logic [19:0] refilt;
        got = 0;
        cyc = 0;
        while (got < 1000 && cyc < 30000) begin
          @(posedge clk);
          #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
          @(negedge clk);
          if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL loop_extra: got 0x%0h with no sample expected", bus.out_data);
            end else begin
              ex = exp_q.pop_front();
              ey = y_q.pop_front();
              w  = bus.out_window;
              refilt = 20'(w[15:0]) + 20'd2 * 20'(w[31:16]) + 20'd3 * 20'(w[47:32])
                       + 20'd4 * 20'(w[63:48]);
              check($sformatf("loop%0d_x", got), {48'd0, bus.out_data}, {48'd0, ex});
              check($sformatf("loop%0d_refilter", got), {44'd0, refilt}, {44'd0, ey});
            end
            got++;
          end
          cyc++;
        end
        if (got < 1000) begin
          checks++;
          errors++;
          $display("FAIL loop_timeout: got %0d samples, required 1000", got);
        end
      end
    join
    bus.out_ready = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
